// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and address checking
// for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    function automatic logic addr_err(
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth_words
    );
        logic [WORD_W-1:0] limit;
        limit = WORD_W'(depth_words) << BYTE_OFF_W;
        return (addr[BYTE_OFF_W-1:0] != '0) || (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write,
// combinational read and asynchronous clear.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder
// with a configurable wait-state count before each access.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              mem_we;
    logic              acc_err;
    logic [WORD_W-1:0] mem_rdata;

    assign acc_err = addr_err(addr_q, DEPTH_WORDS);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .idx_i   (addr_q[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        mem_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    wr_d        = req_write_i;
                    addr_d      = addr_i;
                    wdata_d     = wdata_i;
                    cnt_d       = 4'(LATENCY);
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Faulting accesses never touch the array.
                    mem_we      = wr_q && !acc_err;
                    err_d       = acc_err;
                    rdata_d     = (acc_err || wr_q) ? '0 : mem_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rdata_o     = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and 0)
// checked against a word-array model and a directed table.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_ready;

    logic        rv2, rr2, vo2, er2;
    logic [31:0] rd2;
    logic        rv0, rr0, vo0, er0;
    logic [31:0] rd0;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rdata;

    int total;
    int bad;

    logic [31:0] mem2 [128];
    logic [31:0] mem0 [128];

    assign rv2 = req_valid & ~sel;
    assign rv0 = req_valid & sel;

    assign req_ready = sel ? rr0 : rr2;
    assign rsp_valid = sel ? vo0 : vo2;
    assign rsp_err   = sel ? er0 : er2;
    assign rdata     = sel ? rd0 : rd2;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_l2 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (rv2),
        .req_ready_o (rr2),
        .req_write_i (req_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rsp_valid_o (vo2),
        .rsp_ready_i (rsp_ready),
        .rdata_o     (rd2),
        .rsp_err_o   (er2)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) u_l0 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (rv0),
        .req_ready_o (rr0),
        .req_write_i (req_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rsp_valid_o (vo0),
        .rsp_ready_i (rsp_ready),
        .rdata_o     (rd0),
        .rsp_err_o   (er0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)",
                     n, act, exp, sel, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_ready2", 32'(rr2), 32'd1);
        chk("rst_valid2", 32'(vo2), 32'd0);
        chk("rst_rdata2", rd2, 32'd0);
        chk("rst_err2", 32'(er2), 32'd0);
        chk("rst_ready0", 32'(rr0), 32'd1);
        chk("rst_valid0", 32'(vo0), 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_err0", 32'(er0), 32'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 128; i++) begin
            mem2[i] = '0;
            mem0[i] = '0;
        end
    endtask

    // Expected response from the architectural rules alone.
    task automatic model(input bit wr, input logic [31:0] a,
                         input logic [31:0] d,
                         output logic [31:0] rd, output bit er);
        int idx;
        er  = (a % 4 != 0) || (a >= 32'd512);
        rd  = '0;
        idx = int'(a / 4);
        if (!er) begin
            if (wr) begin
                if (sel) mem0[idx] = d;
                else     mem2[idx] = d;
            end else begin
                rd = sel ? mem0[idx] : mem2[idx];
            end
        end
    endtask

    task automatic xact(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int stall,
                        output logic [31:0] rd, output bit er);
        int          k;
        int          lat;
        logic [31:0] erd;
        bit          eer;
        lat = sel ? 0 : 2;
        model(wr, a, d, erd, eer);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        chk("busy_ready", 32'(req_ready), 32'd0);
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(lat + 1));
        rd = rdata;
        er = rsp_err;
        chk("rdata", rd, erd);
        chk("rsp_err", 32'(er), 32'(eer));
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                addr      = a;
                wdata     = ~d;
            end
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rdata, rd);
            chk("hold_err", 32'(rsp_err), 32'(er));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        bit          sel;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          stall;
        logic [31:0] erd;
        bit          eer;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          er;
        logic [31:0] a;
        int          r;

        tbl[0]  = '{0, 1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        0};
        tbl[1]  = '{0, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 0};
        tbl[2]  = '{0, 0, 32'h13,  32'h0,        0, 32'h0,        1};
        tbl[3]  = '{0, 0, 32'h200, 32'h0,        0, 32'h0,        1};
        tbl[4]  = '{0, 0, 32'h0,   32'h0,        0, 32'h0,        0};
        tbl[5]  = '{0, 1, 32'h4,   32'h1234,     5, 32'h0,        0};
        tbl[6]  = '{0, 0, 32'h4,   32'h0,        0, 32'h1234,     0};
        tbl[7]  = '{0, 1, 32'h20,  32'hCAFE0001, 0, 32'h0,        0};
        tbl[8]  = '{0, 0, 32'h20,  32'h0,        0, 32'hCAFE0001, 0};
        tbl[9]  = '{1, 1, 32'h1FC, 32'hA5A5A5A5, 0, 32'h0,        0};
        tbl[10] = '{1, 0, 32'h1FC, 32'h0,        0, 32'hA5A5A5A5, 0};
        tbl[11] = '{1, 1, 32'h1FE, 32'hFFFFFFFF, 0, 32'h0,        1};
        tbl[12] = '{1, 0, 32'h1FC, 32'h0,        0, 32'hA5A5A5A5, 0};
        tbl[13] = '{0, 1, 32'hFFFFFFFC, 32'h1,   0, 32'h0,        1};

        total = 0;
        bad   = 0;
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        rsp_ready = 1'b0;
        clear_model();

        #12;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            sel = tbl[i].sel;
            xact(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].stall, rd, er);
            chk("tbl_rdata", rd, tbl[i].erd);
            chk("tbl_err", 32'(er), 32'(tbl[i].eer));
        end

        // Abort a captured store with reset while it is waiting.
        sel       = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        addr      = 32'h8;
        wdata     = 32'hFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 32'h8, 32'h0, 0, rd, er);
        chk("rst_load8", rd, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 0, rd, er);
        chk("rst_load10", rd, 32'h0);

        for (int i = 0; i < 120; i++) begin
            sel = 1'($urandom);
            r   = int'($urandom_range(0, 7));
            if (r == 0)
                a = ($urandom_range(0, 127) * 4) + $urandom_range(1, 3);
            else if (r == 1)
                a = (r == 1 && $urandom_range(0, 1) == 1) ? $urandom
                    : 32'd512 + $urandom_range(0, 63) * 4;
            else if (r == 2)
                a = (128 - $urandom_range(1, 4)) * 4;
            else
                a = $urandom_range(0, 15) * 4;
            xact(1'($urandom), a, $urandom,
                 int'($urandom_range(0, 3)), rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: services single-word load/store requests issued by the CPU datapath over a valid/ready request channel and a valid/ready response channel, with a configurable access latency. It is the memory-side end of the CPU's data-memory interface and replaces the zero-latency Data_Memory model, so multi-cycle CPU variants can be exercised against realistic wait states. One request is outstanding at a time.

## Interface
- DEPTH_WORDS, 128: number of 32-bit words stored; byte address range 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: extra wait cycles before the access is performed (0..15).
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  CPU presents a request.
- req_ready_o  out  1  responder can accept a request.
- req_write_i  in  1  1 = store, 0 = load; sampled at accept.
- addr_i  in  32  byte address; sampled at accept.
- wdata_i  in  32  store data; sampled at accept.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  CPU consumes the response.
- rdata_o  out  32  load data; 0 for stores and errors.
- rsp_err_o  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i=1, capture req_write_i, addr_i, wdata_i; load wait counter with LATENCY; go to WAIT.
- WAIT: req_ready_o=0. If counter != 0, decrement it. If counter == 0, perform the access at this edge and go to RESP.
- Access: error = (addr[1:0] != 0) or (addr >= 4*DEPTH_WORDS), compared on all 32 bits. On error: no write, rdata_o=0, rsp_err_o=1. Otherwise, a store writes the word at index addr[31:2] and sets rdata_o=0. A load sets rdata_o to the stored word. rsp_err_o=0 in both cases.
- RESP: rsp_valid_o=1. rdata_o and rsp_err_o are held stable. When rsp_ready_i=1, go to IDLE. The next request cannot be accepted in this same cycle.
- Request inputs are ignored outside IDLE. CPU inputs changing after accept have no effect.
- A load that follows a store to the same address returns the stored data. No forwarding is needed because requests are serialized.

## Timing
- Reset (asynchronous, while rst_i=0): state=IDLE, req_ready_o=1, rsp_valid_o=0, rdata_o=0, rsp_err_o=0, counter=0, all memory words=0.
- Reset mid-operation aborts immediately. A captured but unperformed store is discarded.
- Accept at edge N. rsp_valid_o rises after edge N+LATENCY+1.
- With LATENCY=0, WAIT lasts exactly one cycle.
- Response handshake at edge M. req_ready_o rises after edge M.
- Minimum request-to-request spacing is LATENCY+3 cycles when rsp_ready_i is tied high.
- Memory state changes only at the access edge.

## Structure
- Package dmem_pkg holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - WORD_W=32 and BYTE_OFF_W=2;
  - the address-range-check function.
- Sub-module dmem_array holds the storage:
  - DEPTH_WORDS x 32 register array;
  - synchronous write enable;
  - combinational read by index;
  - asynchronous active-low clear.
- The FSM, counter and response registers live in dmem_responder.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10, then load 0x10, with LATENCY=2 and rsp_ready_i=1. Required: rsp_valid_o rises 3 cycles after each accept; the load returns 0xDEADBEEF with rsp_err_o=0.
- Load from 0x13 (misaligned), then from 0x200 (out of range, DEPTH_WORDS=128). Required: both return rsp_err_o=1 and rdata_o=0. A following load from 0x0 returns 0.
- Store 0x1234 to 0x4, but request only 5 cycles after accept (rsp_ready_i held 0 for 5 cycles). Required: rsp_valid_o stays high with stable outputs; req_ready_o stays 0; a second req_valid_i pulse during this time is ignored and no write occurs.
- Set LATENCY=0. Store 0xA5A5A5A5 to 0x1FC (last word), then load it. Required: response 1 cycle after accept; data matches.
- Accept a store of 0xFFFF to 0x8, then assert rst_i=0 in WAIT. Required: all outputs return to reset values immediately; after release, a load of 0x8 returns 0.
- Store to 0x20 while wdata_i changes on the cycle after accept. Required: only the value sampled at accept is written.
